// File: rtl/trivium_pkg.sv
// Shared constants, FSM encoding and the key/IV load helper for the Trivium keystream block.
package trivium_pkg;

   localparam int unsigned KEY_W          = 80;
   localparam int unsigned IV_W           = 80;
   localparam int unsigned STATE_W        = 288;
   localparam int unsigned DEFAULT_WARMUP = 1152;

   // Last bit of register A (s93) and register B (s177), 0-based
   localparam int unsigned A_END = 92;
   localparam int unsigned B_END = 176;

   // Tap indices, 0-based (s_n lives at bit n-1)
   localparam int unsigned T1_A     = 65;   // s66
   localparam int unsigned T1_B     = 92;   // s93
   localparam int unsigned T1_AND_A = 90;   // s91
   localparam int unsigned T1_AND_B = 91;   // s92
   localparam int unsigned T1_X     = 170;  // s171
   localparam int unsigned T2_A     = 161;  // s162
   localparam int unsigned T2_B     = 176;  // s177
   localparam int unsigned T2_AND_A = 174;  // s175
   localparam int unsigned T2_AND_B = 175;  // s176
   localparam int unsigned T2_X     = 263;  // s264
   localparam int unsigned T3_A     = 242;  // s243
   localparam int unsigned T3_B     = 287;  // s288
   localparam int unsigned T3_AND_A = 285;  // s286
   localparam int unsigned T3_AND_B = 286;  // s287
   localparam int unsigned T3_X     = 68;   // s69

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WARMUP = 2'd1,
      RUN    = 2'd2
   } state_e;

   // Initial state: key into A, IV into B, three ones at the top of C
   function automatic logic [STATE_W-1:0] load_state(input logic [KEY_W-1:0] k,
                                                     input logic [IV_W-1:0]  v);
      logic [STATE_W-1:0] s;
      s                          = '0;
      s[KEY_W-1:0]               = k;
      s[A_END+IV_W:A_END+1]      = v;
      s[STATE_W-1:STATE_W-3]     = 3'b111;
      return s;
   endfunction

endpackage

// File: rtl/trivium_round.sv
// One combinational Trivium round: state in -> state out plus keystream bit z.
module trivium_round
   import trivium_pkg::*;
(
   input  logic [STATE_W-1:0] i_s,
   output logic [STATE_W-1:0] o_s,
   output logic               o_z
);

   logic w_t1;
   logic w_t2;
   logic w_t3;
   logic w_n1;
   logic w_n2;
   logic w_n3;

   assign w_t1 = i_s[T1_A] ^ i_s[T1_B];
   assign w_t2 = i_s[T2_A] ^ i_s[T2_B];
   assign w_t3 = i_s[T3_A] ^ i_s[T3_B];
   assign o_z  = w_t1 ^ w_t2 ^ w_t3;

   // Nonlinear feedback for the head of each register
   assign w_n1 = w_t1 ^ (i_s[T1_AND_A] & i_s[T1_AND_B]) ^ i_s[T1_X];
   assign w_n2 = w_t2 ^ (i_s[T2_AND_A] & i_s[T2_AND_B]) ^ i_s[T2_X];
   assign w_n3 = w_t3 ^ (i_s[T3_AND_A] & i_s[T3_AND_B]) ^ i_s[T3_X];

   // Each register shifts up by one, feedback enters at its lowest bit
   assign o_s = {i_s[STATE_W-2:B_END+1], w_n2,
                 i_s[B_END-1:A_END+1],   w_n1,
                 i_s[A_END-1:0],         w_n3};

endmodule

// File: rtl/trivium_stream.sv
// Trivium keystream generator, W rounds per clock, with warm-up FSM and
// valid/ready output register. Optional feature macro: TRIVIUM_CNT_EN adds
// a saturating 32-bit handshake counter on ks_count.
module trivium_stream
   import trivium_pkg::*;
#(
   parameter int unsigned W             = 8,
   parameter int unsigned WARMUP_ROUNDS = DEFAULT_WARMUP
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [KEY_W-1:0] key,
   input  logic [IV_W-1:0]  iv,
   output logic             busy,
   output logic             ks_valid,
   input  logic             ks_ready,
   output logic [W-1:0]     ks_data
`ifdef TRIVIUM_CNT_EN
   ,
   output logic [31:0]      ks_count
`endif
);

   localparam int unsigned CNT_W    = $clog2(WARMUP_ROUNDS + 1);
   localparam int unsigned LAST_CNT = WARMUP_ROUNDS - W;

   state_e             r_state;
   logic [STATE_W-1:0] r_s;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_busy;
   logic               r_valid;
   logic [W-1:0]       r_data;

   logic [STATE_W-1:0] w_next;
   logic [W-1:0]       w_z;
   logic               w_refill;

   // Unrolled chain of W rounds; round j produces keystream bit j
   for (genvar j = 0; j < W; j++) begin : g_round
      logic [STATE_W-1:0] w_in;
      logic [STATE_W-1:0] w_out;
      if (j == 0) begin : g_first
         assign w_in = r_s;
      end else begin : g_next
         assign w_in = g_round[j-1].w_out;
      end
      trivium_round u_round (
         .i_s (w_in),
         .o_s (w_out),
         .o_z (w_z[j])
      );
   end

   assign w_next   = g_round[W-1].w_out;
   assign w_refill = !r_valid || ks_ready;

   // Control FSM, cipher state and output word register; load wins over everything
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_s     <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (load) begin
         r_state <= WARMUP;
         r_s     <= load_state(key, iv);
         r_cnt   <= '0;
         r_busy  <= 1'b1;
         r_valid <= 1'b0;
         r_data  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_state <= IDLE;
            end
            WARMUP: begin
               r_s <= w_next;
               if (r_cnt == CNT_W'(LAST_CNT)) begin
                  r_state <= RUN;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(W);
               end
            end
            RUN: begin
               if (w_refill) begin
                  r_s     <= w_next;
                  r_data  <= w_z;
                  r_valid <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy     = r_busy;
   assign ks_valid = r_valid;
   assign ks_data  = r_data;

`ifdef TRIVIUM_CNT_EN
   logic [31:0] r_ks_cnt;

   // Saturating count of accepted keystream words
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ks_cnt <= '0;
      end else if (load) begin
         r_ks_cnt <= '0;
      end else if (r_valid && ks_ready && (r_ks_cnt != 32'hFFFF_FFFF)) begin
         r_ks_cnt <= r_ks_cnt + 32'd1;
      end
   end

   assign ks_count = r_ks_cnt;
`endif

endmodule

// File: tb/tb_trivium_stream.sv
// Self-checking bench for trivium_stream: W=8, W=1 and W=64 instances against a
// bit-array reference model of the cipher.
module tb_trivium_stream;

   localparam int unsigned WR = 1152;
   localparam int NB  = 512;
   localparam int LIM = 3000;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic [79:0] key;
   logic [79:0] iv;
   logic        rdy8, rdy1, rdy64;
   logic        busy8, busy1, busy64;
   logic        v8, v1, v64;
   logic [7:0]  d8;
   logic [0:0]  d1;
   logic [63:0] d64;
`ifdef TRIVIUM_CNT_EN
   logic [31:0] c8, c1, c64;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit mk [NB];

   typedef struct {
      logic [79:0] k;
      logic [79:0] v;
      int          pct;
      int          lat8;
      int          lat1;
      int          lat64;
   } vec_t;

   vec_t tbl [4];

   always #5 clk = ~clk;

   trivium_stream #(.W(8)) u_dut8 (
      .clk(clk), .rst(rst), .load(load), .key(key), .iv(iv),
      .busy(busy8), .ks_valid(v8), .ks_ready(rdy8), .ks_data(d8)
`ifdef TRIVIUM_CNT_EN
      , .ks_count(c8)
`endif
   );

   trivium_stream #(.W(1)) u_dut1 (
      .clk(clk), .rst(rst), .load(load), .key(key), .iv(iv),
      .busy(busy1), .ks_valid(v1), .ks_ready(rdy1), .ks_data(d1)
`ifdef TRIVIUM_CNT_EN
      , .ks_count(c1)
`endif
   );

   trivium_stream #(.W(64)) u_dut64 (
      .clk(clk), .rst(rst), .load(load), .key(key), .iv(iv),
      .busy(busy64), .ks_valid(v64), .ks_ready(rdy64), .ks_data(d64)
`ifdef TRIVIUM_CNT_EN
      , .ks_count(c64)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_load(input logic [79:0] k, input logic [79:0] v);
      key  = k;
      iv   = v;
      load = 1'b1;
      tick();
      load = 1'b0;
      cyc  = 0;
   endtask

   // Reference: 288 state bits, one long shift with the three register heads overwritten
   task automatic model_gen(input logic [79:0] k, input logic [79:0] v);
      bit s [1:288];
      bit t1, t2, t3, z;
      for (int n = 1; n <= 288; n++) s[n] = 1'b0;
      for (int i = 1; i <= 80; i++) begin
         s[i]      = k[i-1];
         s[93 + i] = v[i-1];
      end
      s[286] = 1'b1;
      s[287] = 1'b1;
      s[288] = 1'b1;
      for (int r = 0; r < int'(WR) + NB; r++) begin
         t1 = s[66]  ^ s[93];
         t2 = s[162] ^ s[177];
         t3 = s[243] ^ s[288];
         z  = t1 ^ t2 ^ t3;
         t1 = t1 ^ (s[91]  & s[92])  ^ s[171];
         t2 = t2 ^ (s[175] & s[176]) ^ s[264];
         t3 = t3 ^ (s[286] & s[287]) ^ s[69];
         for (int n = 288; n > 1; n--) s[n] = s[n-1];
         s[1]   = t3;
         s[94]  = t1;
         s[178] = t2;
         if (r >= int'(WR)) mk[r - int'(WR)] = z;
      end
   endtask

   function automatic logic [63:0] exp_word(input int idx, input int w);
      logic [63:0] e;
      e = '0;
      for (int j = 0; j < w; j++) e[j] = mk[idx + j];
      return e;
   endfunction

   // Drain NB bits from every instance; W=8 ready is random at pct percent
   task automatic collect(input int pct, input int lat8, input int lat1, input int lat64);
      int          i8 = 0, i1 = 0, i64 = 0;
      int          f8 = -1, f1 = -1, f64 = -1;
      bit          stall = 1'b0;
      bit          timed_out = 1'b0;
      logic [7:0]  pd = '0;
      rdy1  = 1'b1;
      rdy64 = 1'b1;
      while (i8 < NB || i1 < NB || i64 < NB) begin
         if (cyc > LIM) begin
            timed_out = 1'b1;
            break;
         end
         if (v8  && f8  < 0) f8  = cyc;
         if (v1  && f1  < 0) f1  = cyc;
         if (v64 && f64 < 0) f64 = cyc;
         if (stall) begin
            check("stall_valid", 64'(v8), 64'(1));
            check("stall_data", 64'(d8), 64'(pd));
         end
         rdy8 = ($urandom_range(0, 99) < pct);
         if (v8 && rdy8 && i8 < NB) begin
            check("w8_word", 64'(d8), exp_word(i8, 8));
            i8 += 8;
         end
         if (v1 && i1 < NB) begin
            check("w1_bit", 64'(d1), exp_word(i1, 1));
            i1 += 1;
         end
         if (v64 && i64 < NB) begin
            check("w64_word", d64, exp_word(i64, 64));
            i64 += 64;
         end
         stall = v8 && !rdy8;
         pd    = d8;
         tick();
      end
      if (timed_out) begin
         n_checks++;
         n_fail++;
         $display("FAIL collect_timeout: got %0d/%0d/%0d bits required %0d", i8, i1, i64, NB);
      end
      check("lat_w8",  64'(f8),  64'(lat8));
      check("lat_w1",  64'(f1),  64'(lat1));
      check("lat_w64", 64'(f64), 64'(lat64));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [79:0] ka, kb, ia, ib;
      rst = 1'b1; load = 1'b0; key = '0; iv = '0;
      rdy8 = 1'b0; rdy1 = 1'b0; rdy64 = 1'b0;

      tbl[0] = '{k: 80'h0, v: 80'h0, pct: 100, lat8: 145, lat1: 1153, lat64: 19};
      tbl[1] = '{k: 80'({$urandom(), $urandom(), $urandom()}),
                 v: 80'({$urandom(), $urandom(), $urandom()}),
                 pct: 30, lat8: 145, lat1: 1153, lat64: 19};
      tbl[2] = '{k: 80'hFFFF_FFFF_FFFF_FFFF_FFFF, v: 80'h0123_4567_89AB_CDEF_1357,
                 pct: 60, lat8: 145, lat1: 1153, lat64: 19};
      tbl[3] = '{k: 80'({$urandom(), $urandom(), $urandom()}),
                 v: 80'({$urandom(), $urandom(), $urandom()}),
                 pct: 100, lat8: 145, lat1: 1153, lat64: 19};

      // Reset values
      #12;
      check("rst_valid8", 64'(v8), 64'(0));
      check("rst_busy8",  64'(busy8), 64'(0));
      check("rst_data8",  64'(d8), 64'(0));
      check("rst_valid1", 64'(v1), 64'(0));
      check("rst_valid64", 64'(v64), 64'(0));
      tick();
      rst = 1'b0;
      repeat (3) tick();
      check("idle_valid8", 64'(v8), 64'(0));
      check("idle_busy8",  64'(busy8), 64'(0));

      // Table-driven runs
      for (int t = 0; t < 4; t++) begin
         model_gen(tbl[t].k, tbl[t].v);
         do_load(tbl[t].k, tbl[t].v);
         check("load_busy8",  64'(busy8), 64'(1));
         check("load_valid8", 64'(v8), 64'(0));
         collect(tbl[t].pct, tbl[t].lat8, tbl[t].lat1, tbl[t].lat64);
      end

      // Reload in the middle of warm-up
      ka = 80'({$urandom(), $urandom(), $urandom()});
      ia = 80'({$urandom(), $urandom(), $urandom()});
      kb = 80'({$urandom(), $urandom(), $urandom()});
      ib = 80'({$urandom(), $urandom(), $urandom()});
      do_load(ka, ia);
      repeat (49) tick();
      check("midwarm_busy_before", 64'(busy8), 64'(1));
      model_gen(kb, ib);
      rdy8 = 1'b1;
      do_load(kb, ib);
      check("midwarm_valid", 64'(v8), 64'(0));
      check("midwarm_busy",  64'(busy8), 64'(1));
      collect(100, 145, 1153, 19);

      // Reload in RUN coinciding with a handshake: that word is dropped
      rdy8 = 1'b1;
      check("midrun_valid_before", 64'(v8), 64'(1));
      ka = 80'({$urandom(), $urandom(), $urandom()});
      ia = 80'({$urandom(), $urandom(), $urandom()});
      model_gen(ka, ia);
      do_load(ka, ia);
      check("midrun_valid", 64'(v8), 64'(0));
      check("midrun_busy",  64'(busy8), 64'(1));
      collect(30, 145, 1153, 19);

      // Asynchronous reset while a word is pending
      rdy8 = 1'b0;
      tick();
      tick();
      check("prerst_valid", 64'(v8), 64'(1));
      #2 rst = 1'b1;
      #1;
      check("async_rst_valid", 64'(v8), 64'(0));
      check("async_rst_busy",  64'(busy8), 64'(0));
      check("async_rst_data",  64'(d8), 64'(0));
      tick();
      rst  = 1'b0;
      rdy8 = 1'b1;
      repeat (20) tick();
      check("postrst_idle_valid8", 64'(v8), 64'(0));
      check("postrst_idle_busy8",  64'(busy8), 64'(0));
      check("postrst_idle_valid64", 64'(v64), 64'(0));

      // Recovery after reset
      model_gen(tbl[0].k, tbl[0].v);
      do_load(tbl[0].k, tbl[0].v);
      collect(100, 145, 1153, 19);

`ifdef TRIVIUM_CNT_EN
      begin
         int hs;
         int guard;
         rdy8 = 1'b0;
         do_load(tbl[3].k, tbl[3].v);
         check("cnt_load_clear", 64'(c8), 64'(0));
         guard = 0;
         while (!v8 && guard < 400) begin tick(); guard++; end
         check("cnt_wait_valid", 64'(v8), 64'(1));
         hs = 0;
         rdy8 = 1'b1;
         while (hs < 100) begin
            if (v8) hs++;
            tick();
         end
         rdy8 = 1'b0;
         check("cnt_100", 64'(c8), 64'(100));
         do_load(tbl[1].k, tbl[1].v);
         check("cnt_reload", 64'(c8), 64'(0));
         guard = 0;
         while (!v8 && guard < 400) begin tick(); guard++; end
         force u_dut8.r_ks_cnt = 32'hFFFF_FFFF;
         #1;
         release u_dut8.r_ks_cnt;
         rdy8 = 1'b1;
         tick();
         rdy8 = 1'b0;
         check("cnt_saturate", 64'(c8), 64'(32'hFFFF_FFFF));
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/trivium_stream.md
Name: trivium_stream

Overview:
Parametrised Trivium keystream generator with runtime key/IV load and W bits per clock (W rounds unrolled per cycle). Sits between a key/IV configuration source and a stream-cipher datapath. Provides a warm-up state machine and a valid/ready output handshake with backpressure.

Parameters:
W, 8, keystream bits per cycle; legal values 1, 2, 4, 8, 16, 32, 64.
WARMUP_ROUNDS, 1152, discarded init rounds; must be a multiple of W and at least W.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
load  input  1  single-cycle request to load key/iv and start init; accepted in any state
key  input  80  key; key[i] = K(i+1)
iv  input  80  IV; iv[i] = IV(i+1)
busy  output  1  high in WARMUP
ks_valid  output  1  ks_data holds a valid keystream word
ks_ready  input  1  consumer accepts the word
ks_data  output  W  keystream; bit 0 is the earliest-generated bit

Behaviour:
- Reset: asynchronous, active-high. Sets FSM=IDLE, state s=0, busy=0, ks_valid=0, ks_data=0, round counter=0.
- Round function (1-indexed s1..s288):
  - t1=s66^s93, t2=s162^s177, t3=s243^s288; z=t1^t2^t3.
  - t1^=s91&s92^s171; t2^=s175&s176^s264; t3^=s286&s287^s69.
  - s1..93<=(t3,s1..92); s94..177<=(t1,s94..176); s178..288<=(t2,s178..287).
- Load (edge where load=1):
  - s1..80=K1..K80, s81..93=0, s94..173=IV1..IV80, s174..177=0, s178..285=0, s286..288=1.
  - Counter cleared, FSM->WARMUP, busy=1, ks_valid=0 next cycle.
  - load has priority over every other event, including a simultaneous handshake; that word is dropped.
- FSM:
  - IDLE: hold; outputs quiet.
  - WARMUP: W rounds per cycle; counter += W. On the cycle the counter reaches WARMUP_ROUNDS-W: busy=0, FSM->RUN.
  - RUN: outputs keystream words.
- Warm-up latency: load at cycle 0 -> WARMUP occupies cycles 1..WARMUP_ROUNDS/W -> first ks_valid=1 at cycle WARMUP_ROUNDS/W+1.
- RUN, output register update:
  - The register refills when ks_valid=0 or (ks_valid&ks_ready).
  - On refill: compute W rounds, ks_data[j]=z of round j, s advances W rounds, ks_valid=1.
  - Otherwise s, ks_data and ks_valid hold: data stays stable under backpressure and no keystream is skipped.
  - Full throughput is one word per cycle with ks_ready held at 1.
- Counter: width $clog2(WARMUP_ROUNDS+1); not used in RUN.
- Reset mid-operation: returns to IDLE immediately; any partial word is lost.

Optional Feature:
TRIVIUM_CNT_EN:
- Defined: adds output ks_count[31:0].
  - Cleared on reset and on load.
  - Increments on each ks_valid&ks_ready handshake.
  - Saturates at 32'hFFFF_FFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package trivium_pkg:
  - KEY_W=80, IV_W=80, STATE_W=288, DEFAULT_WARMUP=1152.
  - FSM enum {IDLE, WARMUP, RUN}.
  - Tap-index constants.
- Sub-module trivium_round: combinational single round (state in -> state out, z out). Instantiated W times in a generate chain inside trivium_stream.

Test Plan:
- W=1, key=0, iv=0, load at cycle 0, ks_ready=1 -> ks_valid rises at cycle 1153; first 512 bits match the C golden model.
- W=8 and W=64, same key/iv as W=1 run, ks_ready=1 -> concatenated words (bit 0 first) equal the W=1 bitstream; first valid at cycles 145 and 19 respectively.
- W=8, random ks_ready at 30% duty -> ks_data is stable while ks_valid&!ks_ready; accepted sequence has no gaps or repeats versus the model.
- Load mid-WARMUP (cycle 50) and mid-RUN with a new key/iv -> ks_valid=0 next cycle; busy=1; output equals a fresh run for the new key/iv.
- rst pulse during RUN with ks_valid=1 -> ks_valid=0 and busy=0 asynchronously; FSM stays IDLE until the next load.
- With TRIVIUM_CNT_EN: 100 handshakes -> ks_count=100; load -> ks_count=0; preset the counter to max (force) plus one handshake -> ks_count stays 32'hFFFF_FFFF.
